hex_display_bank: RTL and testbench

Parametrised, registered multi-digit hexadecimal display driver. Holds a NUM_DIGITS-nibble value and converts each nibble to a 7-segment pattern. Provides load and increment controls, leading-zero blanking, and optional per-digit blinking. It sits between datapath or FSM logic and the board HEX0..HEXn segment pins, replacing per-digit combinational decoders.

---
 rtl/hex_display_pkg.sv | 26 ++
 rtl/hex_seg_lut.sv | 15 +
 rtl/hex_display_bank.sv | 142 ++++++++++++++
 tb/tb_hex_display_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// hex_display_pkg
//   Shared constants and types for the hex display bank.
//   - GLYPH_HI     : 16-entry active-high 7-segment glyph table (bit 0 = a, bit 6 = g)
//   - SEG_BLANK_HI : all-segments-off pattern in active-high form
//   - digit_idx_t  : index type wide enough for up to 8 digits
//   - seg_blank()  : blank pattern as seen on the pins for a given polarity
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK_HI = 7'h00;

    // Standard hex glyphs: 0-9, A, b, C, d, E, F
    localparam logic [6:0] GLYPH_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef logic [2:0] digit_idx_t;

    // Usable in localparam context to fold the reset/blank pattern at elaboration.
    function automatic logic [6:0] seg_blank(input bit active_low);
        return active_low ? ~SEG_BLANK_HI : SEG_BLANK_HI;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut
//   Combinational 4-bit to 7-segment glyph lookup, active-high output.
//   Ports:
//     nibble  in  4  hex digit value
//     glyph   out 7  segment pattern, bit 0 = a ... bit 6 = g, 1 = lit
module hex_seg_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_HI[nibble];

endmodule

// File: rtl/hex_display_bank.sv
// hex_display_bank
//   Registered multi-digit hexadecimal display driver. Holds a NUM_DIGITS-nibble
//   value, supports load / increment, leading-zero blanking and, when the
//   HEX_BLINK_EN macro is defined, per-digit blinking driven by a free-running
//   divider of BLINK_DIV cycles per half-period.
//   Parameters:
//     NUM_DIGITS      1..8 digits
//     SEG_ACTIVE_LOW  1 = segment lit when driven 0
//     BLINK_DIV       blink half-period in clocks (>= 2), HEX_BLINK_EN builds only
//   Ports:
//     clk         in   system clock, rising edge
//     resetn      in   asynchronous active-low reset
//     load        in   capture value into the display register (wins over inc)
//     value       in   new display value, digit 0 = bits [3:0]
//     inc         in   increment stored value by one (modulo)
//     blank_lz    in   suppress leading zero digits (digit 0 always shown)
//     blink_mask  in   per-digit blink enable
//     seg         out  registered segment patterns, digit d = bits [7d+6:7d]
//     wrap        out  one-cycle pulse when inc rolls all-F to 0
//     value_q     out  current stored value
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_DIV      = 25_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    inc,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    wrap,
    output logic [4*NUM_DIGITS-1:0] value_q
);

    localparam int         VAL_W     = 4 * NUM_DIGITS;
    localparam int         BLINK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = seg_blank(SEG_ACTIVE_LOW != 0);

    function automatic logic [VAL_W-1:0] incr_wrap(input logic [VAL_W-1:0] v);
        return v + VAL_W'(1);
    endfunction

    function automatic logic [6:0] to_pins(input logic [6:0] p);
        return (SEG_ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    // ---- Stage p0: value register and wrap flag ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
            wrap    <= 1'b0;
        end else if (load) begin
            value_q <= value;
            wrap    <= 1'b0;
        end else if (inc) begin
            value_q <= incr_wrap(value_q);
            wrap    <= &value_q;
        end else begin
            wrap    <= 1'b0;
        end
    end

`ifdef HEX_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Free-running divider; load/inc never touch it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end
`else
    // Blinking compiled out: mask and divider width intentionally unused.
    logic [BLINK_W-1:0] unused_blink;
    assign unused_blink = {BLINK_W{^blink_mask}};
`endif

    // Glyph decode, one LUT per digit
    logic [6:0] glyph [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
        hex_seg_lut u_lut (
            .nibble (value_q[4*g +: 4]),
            .glyph  (glyph[g])
        );
    end

    // lz_chain[d] = digit d and every more-significant digit are zero.
    logic [NUM_DIGITS:0]     lz_chain;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic                    show;

    always_comb begin
        lz_chain             = '0;
        lz_chain[NUM_DIGITS] = 1'b1;
        seg_d                = '0;
        show                 = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            lz_chain[d] = lz_chain[d+1] && (value_q[4*d +: 4] == 4'h0);
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            show = 1'b1;
            if (blank_lz && (d != 0) && lz_chain[d]) begin
                show = 1'b0;
            end
`ifdef HEX_BLINK_EN
            if (blink_phase && blink_mask[d]) begin
                show = 1'b0;
            end
`endif
            seg_d[7*d +: 7] = to_pins(show ? glyph[d] : SEG_BLANK_HI);
        end
    end

    // ---- Stage p1: segment output register ----
    logic [7*NUM_DIGITS-1:0] seg_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg_p1 <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            seg_p1 <= seg_d;
        end
    end

    assign seg = seg_p1;

endmodule

// File: tb/tb_hex_display_bank.sv
module tb_hex_display_bank;

    localparam int BDIV = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load;
    logic [15:0] value;
    logic        inc;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [27:0] seg;
    logic        wrap;
    logic [15:0] value_q;

    hex_display_bank #(
        .NUM_DIGITS     (4),
        .SEG_ACTIVE_LOW (1),
        .BLINK_DIV      (BDIV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .inc        (inc),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg        (seg),
        .wrap       (wrap),
        .value_q    (value_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] seg;
        logic [15:0] val;
        logic        wrap;
    } exp_t;

    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    // Active-low glyphs as they appear on the pins
    logic [6:0] gl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [15:0] m_val   = '0;
    int          m_cnt   = 0;
    logic        m_phase = 1'b0;

    function automatic logic [27:0] model_seg(input logic [15:0] v, input logic b,
                                              input logic [3:0] m, input logic ph);
        logic [27:0] s;
        logic        lead;
        logic        off;
        logic [3:0]  nib;
        s    = '0;
        lead = 1'b1;
        for (int d = 3; d >= 0; d--) begin
            nib  = v[4*d +: 4];
            lead = lead && (nib == 4'h0);
            off  = (b && lead && (d != 0)) || (ph && m[d]);
            s[7*d +: 7] = off ? 7'h7F : gl[nib];
        end
        return s;
    endfunction

    task automatic chk1(input string tag, input logic a, input logic e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, a, e);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] a, input logic [15:0] e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, a, e);
        end
    endtask

    task automatic chk28(input string tag, input logic [27:0] a, input logic [27:0] e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, a, e);
        end
    endtask

    // One clock cycle: drive inputs, push the model's prediction, compare after the edge.
    task automatic cyc(input logic l, input logic [15:0] v, input logic i,
                       input logic b, input logic [3:0] m);
        exp_t e;
        @(negedge clk);
        load = l; value = v; inc = i; blank_lz = b; blink_mask = m;
        e.seg = model_seg(m_val, b, m, m_phase);
        if (l) begin
            e.val = v;            e.wrap = 1'b0;
        end else if (i) begin
            e.val = m_val + 16'd1; e.wrap = (m_val == 16'hFFFF);
        end else begin
            e.val = m_val;        e.wrap = 1'b0;
        end
        sbq.push_back(e);
        m_val = e.val;
`ifdef HEX_BLINK_EN
        if (m_cnt == BDIV - 1) begin
            m_cnt = 0; m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
`endif
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++; bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk28("sb_seg", seg, e.seg);
            chk16("sb_value_q", value_q, e.val);
            chk1("sb_wrap", wrap, e.wrap);
        end
    endtask

    task automatic model_reset();
        m_val = '0; m_cnt = 0; m_phase = 1'b0;
        sbq.delete();
    endtask

    initial begin
        int lit;
        logic [15:0] rv;
        resetn = 1'b0; load = 1'b0; value = '0; inc = 1'b0;
        blank_lz = 1'b0; blink_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk28("rst_seg", seg, 28'hFFFFFFF);
        chk16("rst_value_q", value_q, 16'h0000);
        chk1("rst_wrap", wrap, 1'b0);
        resetn = 1'b1;

        // First edge after release: "0000"
        cyc(0, 16'h0, 0, 0, 4'h0);
        chk28("first_zero", seg, {7'h40, 7'h40, 7'h40, 7'h40});

        // Plain load and decode
        cyc(1, 16'h1A3F, 0, 0, 4'h0);
        cyc(0, 16'h0, 0, 0, 4'h0);
        chk28("glyph_1A3F", seg, {7'h79, 7'h08, 7'h30, 7'h0E});

        // Leading-zero blanking
        cyc(1, 16'h00C0, 0, 1, 4'h0);
        cyc(0, 16'h0, 0, 1, 4'h0);
        chk28("lz_00C0", seg, {7'h7F, 7'h7F, 7'h46, 7'h40});
        cyc(1, 16'h0000, 0, 1, 4'h0);
        cyc(0, 16'h0, 0, 1, 4'h0);
        chk28("lz_0000", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        // Interior zero not blanked once a higher digit is non-zero
        cyc(1, 16'h0305, 0, 1, 4'h0);
        cyc(0, 16'h0, 0, 1, 4'h0);
        chk28("lz_0305", seg, {7'h7F, 7'h30, 7'h40, 7'h12});

        // Increment through the wrap point
        cyc(1, 16'hFFFE, 0, 0, 4'h0);
        cyc(0, 16'h0, 1, 0, 4'h0);
        chk16("inc_ffff", value_q, 16'hFFFF);
        chk1("inc_ffff_wrap", wrap, 1'b0);
        cyc(0, 16'h0, 1, 0, 4'h0);
        chk16("inc_0000", value_q, 16'h0000);
        chk1("inc_0000_wrap", wrap, 1'b1);
        cyc(0, 16'h0, 1, 0, 4'h0);
        chk16("inc_0001", value_q, 16'h0001);
        chk1("inc_0001_wrap", wrap, 1'b0);

        // load beats inc, and load of FFFF never pulses wrap
        cyc(1, 16'h0005, 1, 0, 4'h0);
        chk16("load_wins", value_q, 16'h0005);
        chk1("load_wins_wrap", wrap, 1'b0);
        cyc(1, 16'hFFFF, 1, 0, 4'h0);
        chk1("load_ffff_wrap", wrap, 1'b0);

        // Randomised mix, including back-to-back incs
        for (int k = 0; k < 40; k++) begin
            rv = 16'($urandom);
            if (k % 10 == 0) rv = 16'hFFFD;
            cyc(($urandom_range(0, 5) == 0) || (k % 10 == 0), rv,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
        end

        // Blink: digit 0 masked on a value of zero
        cyc(1, 16'h0000, 0, 0, 4'h1);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(0, 16'h0, 0, 0, 4'h1);
            if (seg[6:0] == 7'h40) lit++;
            chk28("blink_steady_hi", {seg[27:7], 7'h00}, {7'h40, 7'h40, 7'h40, 7'h00});
        end
`ifdef HEX_BLINK_EN
        chk1("blink_half_lit", (lit >= 7) && (lit <= 9), 1'b1);
`else
        chk1("blink_ignored", lit == 16, 1'b1);
`endif

        // Asynchronous reset mid-operation drops a pending wrap
        cyc(1, 16'hFFFF, 0, 0, 4'h0);
        cyc(0, 16'h0, 1, 0, 4'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk16("async_rst_value_q", value_q, 16'h0000);
        chk1("async_rst_wrap", wrap, 1'b0);
        chk28("async_rst_seg", seg, 28'hFFFFFFF);
        load = 1'b0; inc = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        model_reset();
        resetn = 1'b1;
        cyc(0, 16'h0, 1, 1, 4'h0);
        chk28("post_rst_seg", seg, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        cyc(0, 16'h0, 1, 1, 4'h0);
        chk16("post_rst_value_q", value_q, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
